float_alu_arbiter: RTL and testbench
====================================

Name: float_alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one float_alu instance among N_REQ requesters.
- Accepts one operation at a time from the requester whose turn it is, drives it into the ALU, and waits for the ALU result.
- Returns the result and flags to the originating requester only.
- A watchdog aborts an ALU operation that hangs.
- Sits between the issue ports of multiple consumers (e.g. the scalar FP pipe and the vector sequencer) and the single float_alu.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, maximum cycles in WAIT before abort (≥4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_op_a  in  32*N_REQ  operand A, requester i at bits [32i+31:32i]
req_op_b  in  32*N_REQ  operand B, same packing
req_op_code  in  3*N_REQ  ALU op code, same packing
req_round_mode  in  N_REQ  0 = nearest even, 1 = toward zero
req_mode_fp  in  N_REQ  1 = single
resp_valid  out  N_REQ  one-hot response valid
resp_ready  in  N_REQ  per-requester response accept
resp_result  out  32  result of the completed op
resp_flags  out  5  XZOUI flags of the completed op
resp_timeout  out  1  qualifies resp_valid: op aborted by watchdog
alu_op_a, alu_op_b  out  32  to float_alu
alu_op_code  out  3  to float_alu
alu_round_mode, alu_mode_fp  out  1  to float_alu
alu_start  out  1  to float_alu start
alu_ready_out  in  1  float_alu can accept start
alu_valid_out  in  1  float_alu result valid
alu_result  in  32  float_alu result
alu_flags  in  5  float_alu flags
alu_ready_in  out  1  to float_alu ready_in

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, rr_ptr = 0, wd_cnt = 0.
  - req_ready = 0, resp_valid = 0, resp_result = 0, resp_flags = 0, resp_timeout = 0.
  - alu_start = 0; all alu_* operand outputs = 0.
  - An in-flight ALU op is discarded.
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - req_ready = onehot(grant), combinational from req_valid and state.
  - On the edge with any req_valid: latch grantee's op_a, op_b, op_code, round_mode, mode_fp and grant index; go to ISSUE.
  - No req_valid: stay.
- ISSUE:
  - alu_start = 1, operands driven from latches, stable until accepted.
  - Accept on the edge where alu_start && alu_ready_out; go to WAIT, wd_cnt = 0.
  - Watchdog does not run in ISSUE.
- WAIT:
  - alu_start = 0; wd_cnt increments each cycle.
  - On alu_valid_out: capture alu_result/alu_flags into resp regs, resp_timeout = 0, go to RESP.
  - Else if wd_cnt == TIMEOUT-1: resp_result = 32'h7FC0_0000, resp_flags = 0, resp_timeout = 1, go to RESP.
  - Simultaneous valid and timeout: valid wins.
- RESP:
  - resp_valid = onehot(grant index); result, flags and timeout held stable.
  - On resp_ready[grant]: rr_ptr = (grant+1) mod N_REQ, resp_valid drops next cycle, go to IDLE.
  - resp_ready on non-granted lines is ignored.
- alu_ready_in:
  - 1 in IDLE, ISSUE and WAIT; 0 in RESP.
  - alu_valid_out outside WAIT is a stray result (post-reset or post-timeout); it is drained and dropped, with no state change.
- Throughput: one op in flight.
  - Minimum request-to-response latency = 2 + ALU latency cycles (IDLE accept, ISSUE accept, WAIT until valid, RESP).
  - Back-to-back: next accept is in the IDLE cycle after RESP handshake.
- Fairness: a requester holding req_valid is granted within N_REQ ops.
- Requester may drop req_valid before being granted; it is then skipped.

Test Plan:
- Single requester 0: ADD 32'h41A6_0000 + 32'h4010_0000, rn = 0, fp = 1 → req_ready[0] pulses once; alu_start held until alu_ready_out; resp_valid = 4'b0001; resp_result = 32'h41B8_0000; resp_flags = 0; resp_timeout = 0.
- All four requesters valid continuously, op_a = i: grant order 0,1,2,3,0. Then rr_ptr = 2 after serving 1 with only req 0 and 3 valid → next grant is 3.
- resp_ready low for 5 cycles in RESP → resp_valid, resp_result and resp_flags are stable; req_ready stays 0 for all; no new alu_start.
- ALU model never asserts valid, TIMEOUT = 8 → resp_valid after 8 WAIT cycles with resp_result = 32'h7FC0_0000 and resp_timeout = 1. A late alu_valid_out arriving in IDLE is dropped; the next op returns the correct result.
- rst asserted during WAIT → outputs zero immediately (asynchronous); after release, the ALU's late valid_out is drained with no resp_valid. A new request to requester 2 completes normally with rr_ptr = 0 search.
- alu_valid_out and the final watchdog cycle coincide → real result returned, resp_timeout = 0.

Source files
------------

// File: rtl/float_alu_arbiter.sv
// float_alu_arbiter: round-robin sequencer that shares one float_alu among
// N_REQ requesters. One operation is in flight at a time. The result goes
// back only to the requester that issued the operation. A watchdog aborts an
// ALU operation that never completes and returns a quiet NaN with
// resp_timeout set.
module float_alu_arbiter #(
  parameter int N_REQ   = 4,   // number of requesters, 2..8
  parameter int TIMEOUT = 64   // WAIT cycles before abort, >= 4
) (
  input  logic                 clk,
  input  logic                 rst,

  // Requester issue side
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_op_a,
  input  logic [32*N_REQ-1:0]  req_op_b,
  input  logic [3*N_REQ-1:0]   req_op_code,
  input  logic [N_REQ-1:0]     req_round_mode,
  input  logic [N_REQ-1:0]     req_mode_fp,

  // Requester response side
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [31:0]          resp_result,
  output logic [4:0]           resp_flags,
  output logic                 resp_timeout,

  // Shared float_alu
  output logic [31:0]          alu_op_a,
  output logic [31:0]          alu_op_b,
  output logic [2:0]           alu_op_code,
  output logic                 alu_round_mode,
  output logic                 alu_mode_fp,
  output logic                 alu_start,
  input  logic                 alu_ready_out,
  input  logic                 alu_valid_out,
  input  logic [31:0]          alu_result,
  input  logic [4:0]           alu_flags,
  output logic                 alu_ready_in
);

  localparam int          IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          WW       = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;     // first requester searched in IDLE
  logic [IW-1:0]   gnt_idx;    // owner of the operation in flight
  logic [WW-1:0]   wd_cnt;     // WAIT cycles elapsed
  logic [IW-1:0]   grant;
  logic            any_valid;

  // Round-robin search: the lowest offset from rr_ptr with req_valid wins.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    idx       = 0;
    any_valid = 1'b0;
    grant     = '0;
    // Walk from the farthest offset down so the nearest valid one is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = IW'(idx);
      end
    end
  end

  // Accept is combinational so the requester sees it in the cycle it is taken.
  assign req_ready = (state == S_IDLE && any_valid) ? (ONE << grant) : '0;

  // The ALU result port is open in every state except RESP. Stray results
  // that arrive in IDLE or ISSUE are accepted and discarded.
  assign alu_ready_in = (state != S_RESP);

  // Sequencer FSM with registered ALU-side and response-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      wd_cnt         <= '0;
      // NOTE: the operand registers are reset as well because they drive
      // module outputs, and those outputs must read zero while rst is high.
      alu_op_a       <= '0;
      alu_op_b       <= '0;
      alu_op_code    <= '0;
      alu_round_mode <= 1'b0;
      alu_mode_fp    <= 1'b0;
      alu_start      <= 1'b0;
      resp_valid     <= '0;
      resp_result    <= '0;
      resp_flags     <= '0;
      resp_timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision in this
      // block sees the register values from before the edge.
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            alu_op_a       <= req_op_a[32*grant +: 32];
            alu_op_b       <= req_op_b[32*grant +: 32];
            alu_op_code    <= req_op_code[3*grant +: 3];
            alu_round_mode <= req_round_mode[grant];
            alu_mode_fp    <= req_mode_fp[grant];
            gnt_idx        <= grant;
            alu_start      <= 1'b1;
            state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Operands stay put until the ALU takes them. The watchdog is idle here.
          if (alu_start && alu_ready_out) begin
            alu_start <= 1'b0;
            wd_cnt    <= '0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A real result that arrives in the last watchdog cycle still wins.
          if (alu_valid_out) begin
            resp_result  <= alu_result;
            resp_flags   <= alu_flags;
            resp_timeout <= 1'b0;
            resp_valid   <= ONE << gnt_idx;
            state        <= S_RESP;
          end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
            resp_result  <= QNAN;
            resp_flags   <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= ONE << gnt_idx;
            state        <= S_RESP;
          end
        end

        S_RESP: begin
          // Only the owner's resp_ready counts. The others are ignored.
          if (resp_ready[gnt_idx]) begin
            resp_valid <= '0;
            rr_ptr     <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_alu_arbiter.sv
// Directed testbench for float_alu_arbiter. The bench plays the float_alu
// role itself: it drives alu_ready_out, alu_valid_out and alu_result
// step by step. All expected values are hand-computed constants.
module tb_float_alu_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_op_a;
  logic [32*N-1:0] req_op_b;
  logic [3*N-1:0] req_op_code;
  logic [N-1:0]   req_round_mode;
  logic [N-1:0]   req_mode_fp;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [31:0]    resp_result;
  logic [4:0]     resp_flags;
  logic           resp_timeout;
  logic [31:0]    alu_op_a;
  logic [31:0]    alu_op_b;
  logic [2:0]     alu_op_code;
  logic           alu_round_mode;
  logic           alu_mode_fp;
  logic           alu_start;
  logic           alu_ready_out;
  logic           alu_valid_out;
  logic [31:0]    alu_result;
  logic [4:0]     alu_flags;
  logic           alu_ready_in;

  int checks = 0;
  int errors = 0;

  float_alu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op_a       (req_op_a),
    .req_op_b       (req_op_b),
    .req_op_code    (req_op_code),
    .req_round_mode (req_round_mode),
    .req_mode_fp    (req_mode_fp),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (resp_result),
    .resp_flags     (resp_flags),
    .resp_timeout   (resp_timeout),
    .alu_op_a       (alu_op_a),
    .alu_op_b       (alu_op_b),
    .alu_op_code    (alu_op_code),
    .alu_round_mode (alu_round_mode),
    .alu_mode_fp    (alu_mode_fp),
    .alu_start      (alu_start),
    .alu_ready_out  (alu_ready_out),
    .alu_valid_out  (alu_valid_out),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .alu_ready_in   (alu_ready_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in ISSUE. Accept the start, then return a result after lat WAIT
  // cycles. Returns with the DUT in RESP.
  task automatic alu_serve(input int lat, input logic [31:0] res, input logic [4:0] flg);
    alu_ready_out = 1'b1;
    tick();
    alu_ready_out = 1'b0;
    repeat (lat - 1) tick();
    alu_valid_out = 1'b1;
    alu_result    = res;
    alu_flags     = flg;
    tick();
    alu_valid_out = 1'b0;
  endtask

  task automatic handshake(input logic [N-1:0] who);
    resp_ready = who;
    tick();
    resp_ready = '0;
  endtask

  initial begin
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};

    rst            = 1'b1;
    req_valid      = '0;
    req_op_a       = '0;
    req_op_b       = '0;
    req_op_code    = '0;
    req_round_mode = '0;
    req_mode_fp    = '0;
    resp_ready     = '0;
    alu_ready_out  = 1'b0;
    alu_valid_out  = 1'b0;
    alu_result     = '0;
    alu_flags      = '0;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(req_ready),    32'h0);
    check("rst_resp_valid", 32'(resp_valid),   32'h0);
    check("rst_resp_res",   resp_result,       32'h0);
    check("rst_alu_start",  32'(alu_start),    32'h0);
    check("rst_alu_op_a",   alu_op_a,          32'h0);
    check("rst_ready_in",   32'(alu_ready_in), 32'h1);
    rst = 1'b0;
    tick();

    // ---- Single requester 0: 20.75 + 2.25 = 23.0 ----
    req_op_a[31:0]    = 32'h41A6_0000;
    req_op_b[31:0]    = 32'h4010_0000;
    req_op_code[2:0]  = 3'd0;
    req_round_mode[0] = 1'b0;
    req_mode_fp[0]    = 1'b1;
    req_valid         = 4'b0001;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    check("t1_req_ready_issue", 32'(req_ready), 32'h0);
    req_valid = '0;
    check("t1_start",   32'(alu_start),   32'h1);
    check("t1_op_a",    alu_op_a,         32'h41A6_0000);
    check("t1_op_b",    alu_op_b,         32'h4010_0000);
    check("t1_mode_fp", 32'(alu_mode_fp), 32'h1);
    tick();
    check("t1_start_held", 32'(alu_start), 32'h1);
    alu_serve(2, 32'h41B8_0000, 5'b0);
    check("t1_start_drop",  32'(alu_start),    32'h0);
    check("t1_resp_valid",  32'(resp_valid),   32'h1);
    check("t1_resp_result", resp_result,       32'h41B8_0000);
    check("t1_resp_flags",  32'(resp_flags),   32'h0);
    check("t1_resp_to",     32'(resp_timeout), 32'h0);
    check("t1_ready_in",    32'(alu_ready_in), 32'h0);
    handshake(4'b0001);
    check("t1_resp_drop", 32'(resp_valid), 32'h0);

    // ---- Round robin with all four requesters valid (restart from rr_ptr 0) ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) req_op_a[32*i +: 32] = 32'(i);
    req_valid = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      #1;
      check("rr_req_ready", 32'(req_ready), 32'(1 << exp_g[s]));
      tick();
      check("rr_op_a", alu_op_a, 32'(exp_g[s]));
      alu_serve(1, 32'h100 + 32'(exp_g[s]), 5'b0);
      check("rr_resp_valid",  32'(resp_valid), 32'(1 << exp_g[s]));
      check("rr_resp_result", resp_result,     32'h100 + 32'(exp_g[s]));
      handshake(4'(1 << exp_g[s]));
    end
    // rr_ptr is now 2. With only 0 and 3 valid, the next grant is 3.
    req_valid = 4'b1001;
    #1;
    check("rr_skip_to_3", 32'(req_ready), 32'h8);
    tick();

    // ---- Response held for 5 cycles while resp_ready is low ----
    alu_serve(2, 32'hC0A0_0000, 5'b00101);
    for (int c = 0; c < 5; c++) begin
      resp_ready = 4'b0001;  // a non-granted line, which must be ignored
      check("hold_resp_valid",  32'(resp_valid), 32'h8);
      check("hold_resp_result", resp_result,     32'hC0A0_0000);
      check("hold_resp_flags",  32'(resp_flags), 32'h5);
      check("hold_req_ready",   32'(req_ready),  32'h0);
      check("hold_alu_start",   32'(alu_start),  32'h0);
      tick();
    end
    resp_ready = '0;
    handshake(4'b1000);
    req_valid = '0;

    // ---- Watchdog timeout (rr_ptr 0, requester 1) ----
    req_valid = 4'b0010;
    #1;
    check("to_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid     = '0;
    alu_ready_out = 1'b1;
    tick();
    alu_ready_out = 1'b0;
    for (int w = 1; w < TO; w++) begin
      tick();
      check("to_wait_no_resp", 32'(resp_valid), 32'h0);
    end
    tick();
    check("to_resp_valid",  32'(resp_valid),   32'h2);
    check("to_resp_result", resp_result,       32'h7FC0_0000);
    check("to_resp_flags",  32'(resp_flags),   32'h0);
    check("to_resp_to",     32'(resp_timeout), 32'h1);
    handshake(4'b0010);
    // A late result that arrives in IDLE is dropped.
    alu_valid_out = 1'b1;
    alu_result    = 32'hDEAD_BEEF;
    tick();
    alu_valid_out = 1'b0;
    check("late_no_resp", 32'(resp_valid), 32'h0);
    // The next op (rr_ptr 2, requester 2) completes normally.
    req_op_a[95:64] = 32'h3F80_0000;
    req_valid       = 4'b0100;
    #1;
    check("after_to_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    alu_serve(3, 32'h3F80_0000, 5'b0);
    check("after_to_valid",  32'(resp_valid),   32'h4);
    check("after_to_result", resp_result,       32'h3F80_0000);
    check("after_to_to",     32'(resp_timeout), 32'h0);
    handshake(4'b0100);

    // ---- Reset during WAIT (rr_ptr 3, so requester 0 is granted) ----
    req_op_a[31:0] = 32'h1111_1111;
    req_valid      = 4'b0001;
    #1;
    check("rw_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid     = '0;
    alu_ready_out = 1'b1;
    tick();
    alu_ready_out = 1'b0;
    tick();
    check("rw_op_a_before", alu_op_a, 32'h1111_1111);
    #2;
    rst = 1'b1;
    #1;
    check("rw_op_a_async",  alu_op_a,          32'h0);
    check("rw_result_zero", resp_result,       32'h0);
    check("rw_resp_valid",  32'(resp_valid),   32'h0);
    check("rw_alu_start",   32'(alu_start),    32'h0);
    check("rw_ready_in",    32'(alu_ready_in), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    alu_valid_out = 1'b1;
    alu_result    = 32'h1234_5678;
    tick();
    alu_valid_out = 1'b0;
    tick();
    check("rw_drain_valid",  32'(resp_valid), 32'h0);
    check("rw_drain_result", resp_result,     32'h0);
    req_op_a[95:64] = 32'h4000_0000;
    req_valid       = 4'b0100;
    #1;
    check("rw_req2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    alu_serve(1, 32'h4000_0000, 5'b0);
    check("rw_req2_valid",  32'(resp_valid), 32'h4);
    check("rw_req2_result", resp_result,     32'h4000_0000);
    handshake(4'b0100);

    // ---- Valid coincides with the last watchdog cycle (rr_ptr 3) ----
    req_valid = 4'b1000;
    #1;
    check("co_req_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid     = '0;
    alu_ready_out = 1'b1;
    tick();
    alu_ready_out = 1'b0;
    repeat (TO - 1) tick();
    alu_valid_out = 1'b1;
    alu_result    = 32'h4049_0FDB;
    alu_flags     = 5'b00001;
    tick();
    alu_valid_out = 1'b0;
    check("co_resp_valid",  32'(resp_valid),   32'h8);
    check("co_resp_result", resp_result,       32'h4049_0FDB);
    check("co_resp_flags",  32'(resp_flags),   32'h1);
    check("co_resp_to",     32'(resp_timeout), 32'h0);
    handshake(4'b1000);
    check("co_resp_drop", 32'(resp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
